// File: rtl/fixed_point_requantizer.sv
// Fixed-point requantizer: converts a signed Q(DIN_WIDTH-DIN_FRAC).DIN_FRAC
// sample to Q(DOUT_WIDTH-DOUT_FRAC).DOUT_FRAC with selectable truncate/round
// and saturate/wrap behaviour. The pipeline has two stages: scale/round, then
// range check/saturate. It also keeps a saturating count of delivered samples
// that carried an overflow flag.
module fixed_point_requantizer #(
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_FRAC   = 8,
  parameter int DOUT_WIDTH = 8,
  parameter int DOUT_FRAC  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  i_ovr,
  input  logic                  round_mode,
  input  logic                  sat_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  o_ovr,
  input  logic                  ovr_clr,
  output logic [CNT_WIDTH-1:0]  ovr_count
);

  // Positive SH drops fraction bits; negative SH adds them with a left shift.
  localparam int SH  = DIN_FRAC - DOUT_FRAC;
  localparam int LSH = (SH < 0) ? -SH : 0;
  // One guard bit keeps the rounding add from wrapping; LSH bits hold a left shift.
  localparam int SW  = DIN_WIDTH + 1 + LSH;
  // The range check needs at least DOUT_WIDTH bits to slice the sign-extension field.
  localparam int EW  = (SW > DOUT_WIDTH) ? SW : DOUT_WIDTH;

  logic                   en_s;
  logic signed [SW-1:0]   din_ext_s;
  logic signed [SW-1:0]   scaled_s;
  logic                   v1_r;
  logic signed [SW-1:0]   sc_r;
  logic                   sat1_r;
  logic                   ovr1_r;
  logic signed [EW-1:0]   ext_s;
  logic                   oor_s;
  logic [DOUT_WIDTH-1:0]  res_s;
  logic                   m_valid_r;
  logic [DOUT_WIDTH-1:0]  dout_r;
  logic                   o_ovr_r;
  logic [CNT_WIDTH-1:0]   ovr_count_r;

  // A single enable advances every stage; the output register frees up when it is empty or being taken.
  assign en_s      = ~m_valid_r | m_ready;
  assign s_ready   = en_s;
  assign din_ext_s = {{(LSH + 1){din[DIN_WIDTH-1]}}, din};

  generate
    if (SH > 0) begin : g_rshift
      logic signed [SW-1:0] rnd_s;
      logic signed [SW-1:0] sum_s;
      // Add the half-LSB constant when rounding, then drop SH fraction bits with sign fill.
      always_comb begin
        rnd_s = {SW{1'b0}};
        if (round_mode) begin
          rnd_s[SH-1] = 1'b1;
        end else begin
          rnd_s[SH-1] = 1'b0;
        end
        sum_s    = din_ext_s + rnd_s;
        scaled_s = sum_s >>> SH;
      end
    end else begin : g_lshift
      // Gaining fraction bits is exact, so round_mode has nothing to do here.
      always_comb begin
        scaled_s = din_ext_s <<< LSH;
      end
    end
  endgenerate

  // Stage 1 register: scaled value plus the per-sample controls needed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r   <= 1'b0;
      sc_r   <= {SW{1'b0}};
      sat1_r <= 1'b0;
      ovr1_r <= 1'b0;
    end else if (en_s) begin
      v1_r   <= s_valid;
      sc_r   <= scaled_s;
      sat1_r <= sat_en;
      ovr1_r <= i_ovr;
    end
  end

  // Range check: in range only when all bits from the output sign bit upward agree.
  always_comb begin
    ext_s = EW'(sc_r);
    oor_s = ~((&ext_s[EW-1:DOUT_WIDTH-1]) | ~(|ext_s[EW-1:DOUT_WIDTH-1]));
    res_s = ext_s[DOUT_WIDTH-1:0];
    if (oor_s && sat1_r) begin
      if (ext_s[EW-1]) begin
        res_s = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
      end else begin
        res_s = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
      end
    end else begin
      res_s = ext_s[DOUT_WIDTH-1:0];
    end
  end

  // Stage 2 / output register: holds its value while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      dout_r    <= {DOUT_WIDTH{1'b0}};
      o_ovr_r   <= 1'b0;
    end else if (en_s) begin
      m_valid_r <= v1_r;
      dout_r    <= res_s;
      o_ovr_r   <= oor_s | ovr1_r;
    end
  end

  // Overflow event counter: clear wins over increment, and it sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_count_r <= {CNT_WIDTH{1'b0}};
    end else if (ovr_clr) begin
      ovr_count_r <= {CNT_WIDTH{1'b0}};
    end else if (m_valid_r && m_ready && o_ovr_r && !(&ovr_count_r)) begin
      ovr_count_r <= ovr_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign m_valid   = m_valid_r;
  assign dout      = dout_r;
  assign o_ovr     = o_ovr_r;
  assign ovr_count = ovr_count_r;

endmodule

// File: tb/tb_fixed_point_requantizer.sv
// Self-checking bench for fixed_point_requantizer (Q8.8 in, Q4.4 out).
// It uses a scoreboard of expected {o_ovr, dout} and adds directed checks for
// latency, stalls, the overflow counter and reset.
module tb_fixed_point_requantizer;

  localparam int DW = 16;
  localparam int DF = 8;
  localparam int OW = 8;
  localparam int OF = 4;
  localparam int CW = 4;
  localparam int SH = DF - OF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] din = 16'h0000;
  logic          i_ovr = 1'b0;
  logic          round_mode = 1'b0;
  logic          sat_en = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [OW-1:0] dout;
  logic          o_ovr;
  logic          ovr_clr = 1'b0;
  logic [CW-1:0] ovr_count;

  int vectors = 0;
  int miscompares = 0;
  int out_count = 0;
  logic [OW:0] sb_q [$];

  fixed_point_requantizer #(
    .DIN_WIDTH(DW), .DIN_FRAC(DF), .DOUT_WIDTH(OW), .DOUT_FRAC(OF), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .din(din),
    .i_ovr(i_ovr), .round_mode(round_mode), .sat_en(sat_en), .m_valid(m_valid),
    .m_ready(m_ready), .dout(dout), .o_ovr(o_ovr), .ovr_clr(ovr_clr), .ovr_count(ovr_count)
  );

  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic: returns {o_ovr, dout}.
  function automatic logic [OW:0] model(logic [DW-1:0] d, logic rm, logic sat, logic io);
    int x;
    int v;
    logic oor;
    logic [OW-1:0] o;
    x = int'($signed(d));
    v = (x + (rm ? (32'sd1 <<< (SH - 1)) : 32'sd0)) >>> SH;
    oor = (v > 127) || (v < -128);
    if (oor && sat) o = (v < 0) ? 8'h80 : 8'h7F;
    else o = v[OW-1:0];
    return {oor | io, o};
  endfunction

  // Scoreboard: push at accepted inputs, pop and compare at delivered outputs (both seen half a cycle before the edge).
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (m_valid && m_ready) begin
        vectors++;
        out_count++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_unexpected: got dout=%h o_ovr=%b with nothing expected", dout, o_ovr);
        end else begin
          logic [OW:0] exp_v;
          exp_v = sb_q.pop_front();
          if ({o_ovr, dout} !== exp_v) begin
            miscompares++;
            $display("FAIL scoreboard_data: got o_ovr=%b dout=%h expected o_ovr=%b dout=%h",
                     o_ovr, dout, exp_v[OW], exp_v[OW-1:0]);
          end
        end
      end
      if (s_valid && s_ready) sb_q.push_back(model(din, round_mode, sat_en, i_ovr));
    end
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({m_valid, o_ovr, dout, ovr_count} !== {1'b0, 1'b0, 8'h00, 4'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got m_valid=%b o_ovr=%b dout=%h cnt=%h expected all zero",
               m_valid, o_ovr, dout, ovr_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got s_ready=%b m_valid=%b expected 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_rounding();
    logic [DW-1:0] dv [4];
    logic          rv [4];
    logic [OW-1:0] ev [4];
    dv = '{16'h0118, 16'h0118, 16'hFFF8, 16'hFFF8};
    rv = '{1'b0, 1'b1, 1'b0, 1'b1};
    ev = '{8'h11, 8'h12, 8'hFF, 8'h00};
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; din = dv[i]; round_mode = rv[i]; sat_en = 1'b1; i_ovr = 1'b0;
      @(posedge clk); #1;
      s_valid = 1'b0;
      vectors++;
      if (m_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL round_latency_early[%0d]: got m_valid=%b expected 0", i, m_valid);
      end
      @(posedge clk); #1;
      vectors++;
      if ({m_valid, o_ovr, dout} !== {1'b1, 1'b0, ev[i]}) begin
        miscompares++;
        $display("FAIL round_value[%0d]: got m_valid=%b o_ovr=%b dout=%h expected 1 0 %h",
                 i, m_valid, o_ovr, dout, ev[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] dv [3];
    logic          sv [3];
    dv = '{16'h7FFF, 16'h7FFF, 16'h8000};
    sv = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; din = dv[i]; sat_en = sv[i]; round_mode = 1'b0; i_ovr = 1'b0;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (ovr_count !== 4'd3) begin
      miscompares++;
      $display("FAIL sat_ovr_count: got %0d expected 3", ovr_count);
    end
  endtask

  task automatic test_iovr_clr();
    @(posedge clk); #1;
    s_valid = 1'b1; din = 16'h0100; i_ovr = 1'b1; sat_en = 1'b1; round_mode = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0; i_ovr = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({m_valid, o_ovr, dout, ovr_count} !== {1'b1, 1'b1, 8'h10, 4'd3}) begin
      miscompares++;
      $display("FAIL iovr_output: got m_valid=%b o_ovr=%b dout=%h cnt=%0d expected 1 1 10 3",
               m_valid, o_ovr, dout, ovr_count);
    end
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    vectors++;
    if (ovr_count !== 4'd0) begin
      miscompares++;
      $display("FAIL clr_priority: got %0d expected 0", ovr_count);
    end
  endtask

  task automatic test_counter_sat();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; din = 16'h7FFF; sat_en = 1'b1; round_mode = 1'b0; i_ovr = 1'b0;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (ovr_count !== 4'hF) begin
      miscompares++;
      $display("FAIL count_saturate: got %0d expected 15", ovr_count);
    end
  endtask

  task automatic test_inflight_reset();
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b1; din = 16'h7FFF; sat_en = 1'b1; i_ovr = 1'b1;
    @(posedge clk); #1;
    din = 16'h8000;
    @(posedge clk); #1;
    s_valid = 1'b0; i_ovr = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({m_valid, ovr_count, dout} !== {1'b0, 4'h0, 8'h00}) begin
      miscompares++;
      $display("FAIL inflight_reset: got m_valid=%b cnt=%0d dout=%h expected 0 0 00",
               m_valid, ovr_count, dout);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (m_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_output[%0d]: got m_valid=%b expected 0", i, m_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] dv [10];
    logic [OW-1:0] held_d;
    logic          held_o;
    logic          held_ok;
    int k;
    int start_out;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) dv[i] = 16'($urandom_range(0, 4095)) - 16'd2048;
      else dv[i] = 16'($urandom_range(0, 65535));
    end
    k = 0;
    held_ok = 1'b0;
    held_d = 8'h00;
    held_o = 1'b0;
    start_out = out_count;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      m_ready = !(cyc >= 4 && cyc < 7);
      if (k < 10) begin
        s_valid = 1'b1; din = dv[k];
        round_mode = 1'($urandom_range(0, 1)); sat_en = 1'($urandom_range(0, 1));
        i_ovr = 1'($urandom_range(0, 1));
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
      if (m_valid && !m_ready) begin
        vectors++;
        if (s_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_s_ready[%0d]: got %b expected 0", cyc, s_ready);
        end
        if (held_ok) begin
          vectors++;
          if ({o_ovr, dout} !== {held_o, held_d}) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: got o_ovr=%b dout=%h expected %b %h",
                     cyc, o_ovr, dout, held_o, held_d);
          end
        end
        held_d = dout; held_o = o_ovr; held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (s_valid && s_ready) k++;
    end
    m_ready = 1'b1;
    vectors++;
    if (out_count - start_out != 10 || sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL burst_count: got %0d outputs with %0d pending expected 10 and 0",
               out_count - start_out, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_iovr_clr();
    test_counter_sat();
    test_inflight_reset();
    test_back_to_back();
    repeat (4) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
